// File: rtl/linx_boot_sequencer.sv
// -----------------------------------------------------------------------------
// linx_boot_sequencer
//   Takes a Linx core through load, run and exit. Host image beats are buffered
//   in a small FIFO. While the core is held in reset they are replayed onto the
//   core's host write port, one registered pulse per beat. GO releases the core
//   once every buffered beat has been written. Halt and exit are then watched,
//   and an optional watchdog bounds the time spent in RUN.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   cmd_*               command channel from the platform register block
//   host_w*             write port into core memory (host_wvalid is a 1-cycle pulse)
//   core_reset          core reset request, high in every state but RUN and DONE
//   core_halted         core halt indication
//   core_exit_valid/code  MMIO exit pulse and its code
//   watchdog_limit      RUN cycle limit, 0 disables the watchdog
//   state               FSM state: IDLE=0 LOAD=1 DRAIN=2 RUN=3 DONE=4 TIMEOUT=5
//   exit_code           latched exit code
//   run_cycles          saturating count of cycles spent in RUN
//   err_oob, err_cmd    sticky errors: out-of-range beat dropped, LOAD while busy
//
// Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready.
//   cmd_ready is simply !fifo_full for every opcode. LOAD beats accepted in DRAIN
//   or RUN are discarded and flagged on err_cmd. The reserved opcode is accepted
//   and ignored.
// -----------------------------------------------------------------------------
module linx_boot_sequencer #(
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter longint unsigned MEM_BYTES  = 262144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [63:0] cmd_addr,
  input  logic [63:0] cmd_data,
  input  logic [7:0]  cmd_strb,
  output logic        host_wvalid,
  output logic [63:0] host_waddr,
  output logic [63:0] host_wdata,
  output logic [7:0]  host_wstrb,
  output logic        core_reset,
  input  logic        core_halted,
  input  logic        core_exit_valid,
  input  logic [31:0] core_exit_code,
  input  logic [31:0] watchdog_limit,
  output logic [2:0]  state,
  output logic [31:0] exit_code,
  output logic [31:0] run_cycles,
  output logic        err_oob,
  output logic        err_cmd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [64:0]  MEM_LIMIT = 65'(MEM_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic [31:0] run_cycles_q, run_cycles_d;
  logic [31:0] exit_code_q, exit_code_d;
  logic        err_oob_q, err_oob_d;
  logic        err_cmd_q, err_cmd_d;

  // FIFO storage is not reset; the pointers and the count say what is valid.
  logic [63:0]   fifo_addr [FIFO_DEPTH];
  logic [63:0]   fifo_data [FIFO_DEPTH];
  logic [7:0]    fifo_strb [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic        wvalid_q;
  logic [63:0] waddr_q, wdata_q;
  logic [7:0]  wstrb_q;

  logic        fifo_full, fifo_empty;
  logic        cmd_fire, is_load, is_go, is_abort;
  logic        push, pop, head_oob;
  logic [31:0] rc_inc;

  assign fifo_full  = (count_q == DEPTH_CNT);
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = !fifo_full;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign is_load    = cmd_fire && (cmd_op == 2'd0);
  assign is_go      = cmd_fire && (cmd_op == 2'd1);
  assign is_abort   = cmd_fire && (cmd_op == 2'd2);

  assign push = is_load && (state_q == ST_IDLE || state_q == ST_LOAD ||
                            state_q == ST_DONE || state_q == ST_TIMEOUT);
  // ABORT wins over a pop in the same cycle, so the head beat never reaches the core.
  assign pop  = !fifo_empty && (state_q == ST_LOAD || state_q == ST_DRAIN) && !is_abort;

  // Widened to 65 bits so addresses near 2^64 cannot wrap back into range.
  assign head_oob = ({1'b0, fifo_addr[rd_ptr_q]} + 65'd8) > MEM_LIMIT;
  assign rc_inc   = run_cycles_q + 32'd1;

  always_comb begin
    state_d      = state_q;
    run_cycles_d = run_cycles_q;
    exit_code_d  = exit_code_q;
    err_oob_d    = err_oob_q | (pop && head_oob);
    err_cmd_d    = err_cmd_q | (is_load && (state_q == ST_DRAIN || state_q == ST_RUN));
    if (is_abort) begin
      state_d      = ST_IDLE;
      run_cycles_d = '0;
      err_oob_d    = 1'b0;
      err_cmd_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_load)    state_d = ST_LOAD;
          else if (is_go) state_d = ST_DRAIN;
        end
        ST_LOAD: begin
          if (is_go) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          // Wait for the last pulse to leave the write port before releasing the core.
          if (fifo_empty && !wvalid_q) state_d = ST_RUN;
        end
        ST_RUN: begin
          run_cycles_d = (run_cycles_q == '1) ? run_cycles_q : rc_inc;
          if (core_exit_valid) begin
            state_d     = ST_DONE;
            exit_code_d = core_exit_code;
          end else if (core_halted) begin
            state_d = ST_DONE;
          end else if (watchdog_limit != '0 && rc_inc == watchdog_limit) begin
            state_d = ST_TIMEOUT;
          end
        end
        ST_DONE, ST_TIMEOUT: begin
          if (is_load) begin
            state_d      = ST_LOAD;
            run_cycles_d = '0;
            exit_code_d  = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      run_cycles_q <= '0;
      exit_code_q  <= '0;
      err_oob_q    <= 1'b0;
      err_cmd_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cycles_q <= run_cycles_d;
      exit_code_q  <= exit_code_d;
      err_oob_q    <= err_oob_d;
      err_cmd_q    <= err_cmd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= cmd_addr;
      fifo_data[wr_ptr_q] <= cmd_data;
      fifo_strb[wr_ptr_q] <= cmd_strb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (is_abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Write port: address/data/strobes hold their last value between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wvalid_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      wvalid_q <= pop && !head_oob;
      if (pop && !head_oob) begin
        waddr_q <= fifo_addr[rd_ptr_q];
        wdata_q <= fifo_data[rd_ptr_q];
        wstrb_q <= fifo_strb[rd_ptr_q];
      end
    end
  end

  assign host_wvalid = wvalid_q;
  assign host_waddr  = waddr_q;
  assign host_wdata  = wdata_q;
  assign host_wstrb  = wstrb_q;
  assign core_reset  = !(state_q == ST_RUN || state_q == ST_DONE);
  assign state       = state_q;
  assign exit_code   = exit_code_q;
  assign run_cycles  = run_cycles_q;
  assign err_oob     = err_oob_q;
  assign err_cmd     = err_cmd_q;

endmodule

// File: tb/tb_linx_boot_sequencer.sv
module tb_linx_boot_sequencer;

  localparam longint unsigned MEM = 262144;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_addr, cmd_data;
  logic [7:0]  cmd_strb;
  logic        host_wvalid;
  logic [63:0] host_waddr, host_wdata;
  logic [7:0]  host_wstrb;
  logic        core_reset, core_halted, core_exit_valid;
  logic [31:0] core_exit_code, watchdog_limit;
  logic [2:0]  state;
  logic [31:0] exit_code, run_cycles;
  logic        err_oob, err_cmd;

  linx_boot_sequencer #(.FIFO_DEPTH(4), .MEM_BYTES(MEM)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .host_wvalid(host_wvalid), .host_waddr(host_waddr),
    .host_wdata(host_wdata), .host_wstrb(host_wstrb),
    .core_reset(core_reset), .core_halted(core_halted),
    .core_exit_valid(core_exit_valid), .core_exit_code(core_exit_code),
    .watchdog_limit(watchdog_limit), .state(state),
    .exit_code(exit_code), .run_cycles(run_cycles),
    .err_oob(err_oob), .err_cmd(err_cmd)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [135:0] exp_q[$];   // {addr, data, strb} of every beat that must reach the core

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input logic [63:0] a);
    return ({1'b0, a} + 65'd8) <= 65'(MEM);
  endfunction

  // Every write pulse must match the oldest outstanding expected beat.
  always @(negedge clk) begin
    if (host_wvalid === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'(host_wvalid), 64'd0);
      end else begin
        logic [135:0] e;
        e = exp_q.pop_front();
        check("waddr", host_waddr, e[135:72]);
        check("wdata", host_wdata, e[71:8]);
        check("wstrb", 64'(host_wstrb), 64'(e[7:0]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input logic [1:0] op, input logic [63:0] a,
                      input logic [63:0] d, input logic [7:0] s);
    int n = 0;
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // wr: the beat is issued in a phase where it must be buffered and replayed.
  task automatic load(input logic [63:0] a, input logic [63:0] d,
                      input logic [7:0] s, input bit wr);
    send(2'd0, a, d, s);
    if (wr && in_range(a)) exp_q.push_back({a, d, s});
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(state), 64'(s));
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] rnd_addr();
    return 64'($urandom_range(0, int'((MEM - 8) / 8)) * 8);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int n_exit, p0, k;
    bit any_oob;
    logic [63:0] a;
    logic [31:0] code;

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_strb = '0;
    core_halted = 1'b0; core_exit_valid = 1'b0; core_exit_code = '0; watchdog_limit = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_state", 64'(state), 64'd0);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_wvalid", 64'(host_wvalid), 64'd0);
    check("rst_waddr", host_waddr, 64'd0);
    check("rst_wdata", host_wdata, 64'd0);
    check("rst_exit_code", 64'(exit_code), 64'd0);
    check("rst_run_cycles", 64'(run_cycles), 64'd0);
    check("rst_err_oob", 64'(err_oob), 64'd0);
    check("rst_err_cmd", 64'(err_cmd), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // Three beats then GO; exit with 0x2A after a random number of RUN cycles
    p0 = pulses;
    for (int i = 0; i < 3; i++) load(64'(i * 8), rnd64(), 8'hFF, 1'b1);
    send(2'd1, '0, '0, '0);
    wait_state(3'd3, 50, "s1_enter_run");
    check("s1_pulse_count", 64'(pulses - p0), 64'd3);
    check("s1_all_written", 64'(exp_q.size()), 64'd0);
    check("s1_core_reset", 64'(core_reset), 64'd0);
    check("s1_run_start", 64'(run_cycles), 64'd0);
    n_exit = $urandom_range(5, 20);
    repeat (n_exit - 1) @(negedge clk);
    core_exit_valid = 1'b1; core_exit_code = 32'h2A;
    @(negedge clk);
    core_exit_valid = 1'b0; core_exit_code = $urandom;
    check("s1_done_state", 64'(state), 64'd4);
    check("s1_exit_code", 64'(exit_code), 64'h2A);
    check("s1_run_cycles", 64'(run_cycles), 64'(n_exit));
    check("s1_done_core_reset", 64'(core_reset), 64'd0);
    repeat (3) @(negedge clk);
    check("s1_run_frozen", 64'(run_cycles), 64'(n_exit));

    // Back-to-back beats from DONE, with an out-of-range beat in the middle
    load(rnd_addr(), rnd64(), 8'($urandom), 1'b1);
    check("s2_reload_state", 64'(state), 64'd1);
    check("s2_reload_run", 64'(run_cycles), 64'd0);
    check("s2_reload_exit", 64'(exit_code), 64'd0);
    check("s2_reload_core_reset", 64'(core_reset), 64'd1);
    for (int i = 0; i < 4; i++) load(rnd_addr(), rnd64(), 8'($urandom), 1'b1);
    load(64'(MEM - 4), rnd64(), 8'hFF, 1'b1);
    load(rnd_addr(), rnd64(), 8'($urandom), 1'b1);
    send(2'd1, '0, '0, '0);
    wait_state(3'd3, 50, "s2_enter_run");
    check("s2_all_written", 64'(exp_q.size()), 64'd0);
    check("s2_err_oob", 64'(err_oob), 64'd1);
    check("s2_err_cmd_clear", 64'(err_cmd), 64'd0);
    load(rnd_addr(), rnd64(), 8'hFF, 1'b0);
    check("s2_err_cmd", 64'(err_cmd), 64'd1);
    core_halted = 1'b1;
    @(negedge clk);
    core_halted = 1'b0;
    check("s2_halt_state", 64'(state), 64'd4);
    check("s2_halt_exit_code", 64'(exit_code), 64'd0);

    // Watchdog at 100 cycles
    send(2'd2, '0, '0, '0);
    check("s3_abort_state", 64'(state), 64'd0);
    check("s3_abort_err_oob", 64'(err_oob), 64'd0);
    check("s3_abort_err_cmd", 64'(err_cmd), 64'd0);
    check("s3_abort_run", 64'(run_cycles), 64'd0);
    watchdog_limit = 32'd100;
    send(2'd1, '0, '0, '0);
    wait_state(3'd3, 20, "s3_enter_run");
    repeat (99) @(negedge clk);
    check("s3_before_limit", 64'(state), 64'd3);
    check("s3_before_limit_run", 64'(run_cycles), 64'd99);
    @(negedge clk);
    check("s3_timeout_state", 64'(state), 64'd5);
    check("s3_timeout_run", 64'(run_cycles), 64'd100);
    check("s3_timeout_core_reset", 64'(core_reset), 64'd1);
    repeat (3) @(negedge clk);
    check("s3_timeout_frozen", 64'(run_cycles), 64'd100);

    // Limit 0 never fires; then exit and watchdog land on the same cycle
    watchdog_limit = 32'd0;
    load(rnd_addr(), rnd64(), 8'($urandom), 1'b1);
    check("s4_reload_state", 64'(state), 64'd1);
    check("s4_reload_run", 64'(run_cycles), 64'd0);
    send(2'd1, '0, '0, '0);
    wait_state(3'd3, 20, "s4_enter_run");
    repeat (150) @(negedge clk);
    check("s4_no_timeout", 64'(state), 64'd3);
    check("s4_run_count", 64'(run_cycles), 64'd150);
    code = $urandom;
    watchdog_limit = 32'd151;
    core_exit_valid = 1'b1; core_exit_code = code;
    @(negedge clk);
    core_exit_valid = 1'b0; watchdog_limit = 32'd0;
    check("s4_exit_beats_wdog", 64'(state), 64'd4);
    check("s4_exit_code", 64'(exit_code), 64'(code));
    check("s4_run_final", 64'(run_cycles), 64'd151);

    // Randomized image loads, including range boundaries
    for (int it = 0; it < 4; it++) begin
      send(2'd2, '0, '0, '0);
      check("s5_abort_state", 64'(state), 64'd0);
      any_oob = 1'b0;
      k = $urandom_range(1, 6);
      for (int j = 0; j < k; j++) begin
        if (it == 0 && j == 0)      a = 64'(MEM - 8);
        else if (it == 1 && j == 0) a = 64'hFFFF_FFFF_FFFF_FFFC;
        else if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(int'(MEM - 7), int'(MEM + 64)));
        else a = rnd_addr();
        if (!in_range(a)) any_oob = 1'b1;
        load(a, rnd64(), 8'($urandom), 1'b1);
      end
      send(2'd1, '0, '0, '0);
      wait_state(3'd3, 60, "s5_enter_run");
      check("s5_all_written", 64'(exp_q.size()), 64'd0);
      check("s5_err_oob", 64'(err_oob), 64'(any_oob));
      check("s5_core_reset", 64'(core_reset), 64'd0);
    end

    // ABORT cancels the beat about to be written and flushes the FIFO
    send(2'd2, '0, '0, '0);
    p0 = pulses;
    load(rnd_addr(), rnd64(), 8'hFF, 1'b1);
    load(rnd_addr(), rnd64(), 8'hFF, 1'b0);
    send(2'd2, '0, '0, '0);
    repeat (5) @(negedge clk);
    check("s6_abort_state", 64'(state), 64'd0);
    check("s6_abort_pulses", 64'(pulses - p0), 64'd1);
    load(rnd_addr(), rnd64(), 8'h0F, 1'b1);
    send(2'd1, '0, '0, '0);
    wait_state(3'd3, 30, "s6_enter_run");
    check("s6_flushed_pulses", 64'(pulses - p0), 64'd2);
    check("s6_all_written", 64'(exp_q.size()), 64'd0);

    // ABORT in the single DRAIN cycle of an empty GO
    send(2'd2, '0, '0, '0);
    send(2'd1, '0, '0, '0);
    check("s6_drain_state", 64'(state), 64'd2);
    send(2'd2, '0, '0, '0);
    check("s6_drain_abort", 64'(state), 64'd0);
    check("s6_drain_abort_core_reset", 64'(core_reset), 64'd1);

    // Asynchronous reset in the middle of RUN
    send(2'd1, '0, '0, '0);
    wait_state(3'd3, 20, "s7_enter_run");
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("s7_async_core_reset", 64'(core_reset), 64'd1);
    check("s7_async_state", 64'(state), 64'd0);
    check("s7_async_run", 64'(run_cycles), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("s7_post_state", 64'(state), 64'd0);
    check("s7_post_exit", 64'(exit_code), 64'd0);
    check("s7_post_wvalid", 64'(host_wvalid), 64'd0);
    check("s7_post_queue", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
